// File: rtl/control_unit_pkg.sv
// Shared definitions for the microprogrammed control unit: microword layout,
// sequencing/condition encodings, fixed microcode addresses and control constants.
package control_unit_pkg;

  localparam int unsigned CtrlWidth = 21;
  localparam int unsigned SeqWidth  = 2;
  localparam int unsigned CondWidth = 3;
  localparam int unsigned AddrWidth = 7;
  localparam int unsigned WordWidth = CtrlWidth + SeqWidth + CondWidth + AddrWidth;

  typedef enum logic [SeqWidth-1:0] {
    SeqNext     = 2'b00,
    SeqBranch   = 2'b01,
    SeqDispatch = 2'b10,
    SeqEnd      = 2'b11
  } seq_e;

  typedef enum logic [CondWidth-1:0] {
    CondAlways = 3'b000,
    CondZ      = 3'b001,
    CondN      = 3'b010,
    CondC      = 3'b011,
    CondP      = 3'b100,
    CondNotZ   = 3'b101,
    CondInt    = 3'b110,
    CondNever  = 3'b111
  } cond_e;

  typedef struct packed {
    logic [CtrlWidth-1:0] ctrl;
    seq_e                 seq;
    cond_e                cond;
    logic [AddrWidth-1:0] target;
  } uword_t;

  localparam logic [AddrWidth-1:0] FetchAddr    = 7'd0;
  localparam logic [AddrWidth-1:0] DecodeAddr   = 7'd1;
  localparam logic [AddrWidth-1:0] IntAddr      = 7'd4;
  localparam logic [AddrWidth-1:0] IntEndAddr   = 7'd5;
  localparam logic [AddrWidth-1:0] DispatchBase = 7'd8;
  localparam logic [AddrWidth-1:0] DispatchLast = 7'd71;

  localparam logic [CtrlWidth-1:0] CtrlFetch   = 21'h000001;
  localparam logic [CtrlWidth-1:0] CtrlDecode  = 21'h000002;
  localparam logic [CtrlWidth-1:0] CtrlIntBody = 21'h040000;
  localparam logic [CtrlWidth-1:0] CtrlIntEnd  = 21'h020000;
  localparam logic [CtrlWidth-1:0] CtrlOpFirst = 21'h100000;
  localparam logic [CtrlWidth-1:0] CtrlOpLast  = 21'h080000;

endpackage

// File: rtl/control_rom.sv
// 128-word microcode ROM built as a combinational case table.
module control_rom
  import control_unit_pkg::*;
(
  input  logic [AddrWidth-1:0] addr_i,
  output logic [WordWidth-1:0] word_o
);

  uword_t     w;
  logic [4:0] k;

  always_comb begin
    w = '{ctrl: '0, seq: SeqEnd, cond: CondNever, target: '0};
    k = 5'((addr_i - DispatchBase) >> 1);

    if (addr_i == FetchAddr) begin
      w.ctrl = CtrlFetch;
      w.seq  = SeqNext;
    end else if (addr_i == DecodeAddr) begin
      w.ctrl = CtrlDecode;
      w.seq  = SeqDispatch;
    end else if (addr_i == IntAddr) begin
      w.ctrl = CtrlIntBody;
      w.seq  = SeqNext;
    end else if (addr_i == IntEndAddr) begin
      w.ctrl = CtrlIntEnd;
      w.seq  = SeqEnd;
    end else if (addr_i >= DispatchBase && addr_i <= DispatchLast) begin
      if (!addr_i[0]) begin
        w.ctrl = CtrlOpFirst | CtrlWidth'(k);
        w.seq  = SeqNext;
        // Conditional opcodes: a true flag jumps back to fetch, skipping the second word
        case (k)
          5'd16: begin w.seq = SeqBranch; w.cond = CondZ; w.target = FetchAddr; end
          5'd17: begin w.seq = SeqBranch; w.cond = CondN; w.target = FetchAddr; end
          5'd18: begin w.seq = SeqBranch; w.cond = CondC; w.target = FetchAddr; end
          5'd19: begin w.seq = SeqBranch; w.cond = CondP; w.target = FetchAddr; end
          default: ;
        endcase
      end else begin
        w.ctrl = CtrlOpLast | CtrlWidth'(k);
        w.seq  = SeqEnd;
      end
    end
  end

  assign word_o = w;

endmodule

// File: rtl/control_unit.sv
// Microsequencer: holds the micro-PC and picks the next address from the
// current microword's seq/cond fields, the ALU flags, opcode and interrupt.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 intr,  // interrupt request
  input  logic                 Z,
  input  logic                 N,
  input  logic                 C,
  input  logic                 P,
  input  logic [4:0]           opcode,
  output logic [MAX_WIDTH-1:0] uinstruction
);

  logic [AddrWidth-1:0] upc_q = FetchAddr;
  logic [AddrWidth-1:0] upc_d;
  logic [WordWidth-1:0] rom_word;
  uword_t               word;
  logic                 cond_true;

  control_rom u_rom (
    .addr_i (upc_q),
    .word_o (rom_word)
  );

  assign word         = uword_t'(rom_word);
  assign uinstruction = MAX_WIDTH'(word.ctrl);

  always_comb begin
    cond_true = 1'b0;
    unique case (word.cond)
      CondAlways: cond_true = 1'b1;
      CondZ:      cond_true = Z;
      CondN:      cond_true = N;
      CondC:      cond_true = C;
      CondP:      cond_true = P;
      CondNotZ:   cond_true = ~Z;
      CondInt:    cond_true = intr;
      CondNever:  cond_true = 1'b0;
    endcase
  end

  always_comb begin
    upc_d = upc_q + 7'd1;
    unique case (word.seq)
      SeqNext:     upc_d = upc_q + 7'd1;
      SeqBranch:   upc_d = cond_true ? word.target : upc_q + 7'd1;
      SeqDispatch: upc_d = DispatchBase + {1'b0, opcode, 1'b0};
      SeqEnd:      upc_d = intr ? IntAddr : FetchAddr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) upc_q <= FetchAddr;
    else     upc_q <= upc_d;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        intr = 1'b0;
  logic        Z = 1'b0, N = 1'b0, C = 1'b0, P = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [20:0] uinstruction;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  control_unit #(.MAX_WIDTH(21)) dut (
    .clk          (clk),
    .rst          (rst),
    .intr         (intr),
    .Z            (Z),
    .N            (N),
    .C            (C),
    .P            (P),
    .opcode       (opcode),
    .uinstruction (uinstruction)
  );

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_powerup();
    #1;
    tests++;
    if (uinstruction !== 21'h000001) begin
      fails++;
      $display("FAIL powerup: got %h expected 000001", uinstruction);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (uinstruction !== 21'h000001) begin
      fails++;
      $display("FAIL reset: got %h expected 000001", uinstruction);
    end
  endtask

  task automatic test_normal();
    logic [20:0] exp [4] = '{21'h000001, 21'h000002, 21'h100002, 21'h080002};
    opcode = 5'b00010;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (uinstruction !== exp[i % 4]) begin
        fails++;
        $display("FAIL normal step %0d: got %h expected %h", i, uinstruction, exp[i % 4]);
      end
      tick();
    end
  endtask

  task automatic test_dispatch();
    logic [4:0] ops [4] = '{5'd0, 5'd7, 5'd20, 5'd31};
    logic [20:0] exp [5];
    for (int j = 0; j < 4; j++) begin
      opcode = ops[j];
      exp[0] = 21'h000001;
      exp[1] = 21'h000002;
      exp[2] = 21'h100000 | 21'(ops[j]);
      exp[3] = 21'h080000 | 21'(ops[j]);
      exp[4] = 21'h000001;
      do_reset();
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (uinstruction !== exp[i]) begin
          fails++;
          $display("FAIL dispatch op %0d step %0d: got %h expected %h",
                   ops[j], i, uinstruction, exp[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] exp [5];
    int n;
    for (int k = 0; k < 4; k++) begin
      for (int taken = 0; taken < 2; taken++) begin
        opcode = 5'(16 + k);
        // Only the flag under test decides; the other three are set opposite to it
        {Z, N, C, P} = taken != 0 ? 4'b1000 >> k : ~(4'b1000 >> k);
        exp[0] = 21'h000001;
        exp[1] = 21'h000002;
        exp[2] = 21'h100000 | 21'(16 + k);
        if (taken != 0) begin
          exp[3] = 21'h000001;
          n = 4;
        end else begin
          exp[3] = 21'h080000 | 21'(16 + k);
          exp[4] = 21'h000001;
          n = 5;
        end
        do_reset();
        for (int i = 0; i < n; i++) begin
          tests++;
          if (uinstruction !== exp[i]) begin
            fails++;
            $display("FAIL branch op %0d taken %0d step %0d: got %h expected %h",
                     16 + k, taken, i, uinstruction, exp[i]);
          end
          tick();
        end
      end
    end
    {Z, N, C, P} = 4'b0000;
  endtask

  task automatic test_interrupt();
    logic [20:0] exp [8] = '{21'h000001, 21'h000002, 21'h100002, 21'h080002,
                             21'h040000, 21'h020000, 21'h040000, 21'h020000};
    opcode = 5'b00010;
    intr = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (uinstruction !== exp[i]) begin
        fails++;
        $display("FAIL interrupt step %0d: got %h expected %h", i, uinstruction, exp[i]);
      end
      if (i < 7) tick();
    end
    intr = 1'b0;
    tick();
    tests++;
    if (uinstruction !== 21'h000001) begin
      fails++;
      $display("FAIL interrupt release: got %h expected 000001", uinstruction);
    end
  endtask

  task automatic test_int_ignored();
    opcode = 5'b00010;
    do_reset();
    tick();
    tests++;
    if (uinstruction !== 21'h000002) begin
      fails++;
      $display("FAIL int_ignored decode: got %h expected 000002", uinstruction);
    end
    intr = 1'b1;
    tick();
    intr = 1'b0;
    tests++;
    if (uinstruction !== 21'h100002) begin
      fails++;
      $display("FAIL int_ignored first: got %h expected 100002", uinstruction);
    end
    tick();
    tests++;
    if (uinstruction !== 21'h080002) begin
      fails++;
      $display("FAIL int_ignored second: got %h expected 080002", uinstruction);
    end
    tick();
    tests++;
    if (uinstruction !== 21'h000001) begin
      fails++;
      $display("FAIL int_ignored fetch: got %h expected 000001", uinstruction);
    end
  endtask

  task automatic test_mid_reset();
    opcode = 5'b00010;
    do_reset();
    tick();
    tick();
    tests++;
    if (uinstruction !== 21'h100002) begin
      fails++;
      $display("FAIL mid_reset setup: got %h expected 100002", uinstruction);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (uinstruction !== 21'h000001) begin
      fails++;
      $display("FAIL mid_reset: got %h expected 000001", uinstruction);
    end
    tick();
    tests++;
    if (uinstruction !== 21'h000002) begin
      fails++;
      $display("FAIL mid_reset resume: got %h expected 000002", uinstruction);
    end
  endtask

  initial begin
    test_powerup();
    test_reset();
    test_normal();
    test_dispatch();
    test_branch();
    test_interrupt();
    test_int_ignored();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 21, width of the microinstruction output; only 21 is required to be supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port int, input, 1, the interrupt request, sampled only at fetch boundaries.
REQ-005 SHALL have ports Z, N, C, P, input, 1 each, the zero, negative, carry and positive (parity) ALU flags used as branch conditions.
REQ-006 SHALL have port opcode, input, 5, the macro-instruction opcode used for dispatch.
REQ-007 SHALL have port uinstruction, output, MAX_WIDTH, the control field of the current microword.

Function
REQ-008 SHALL hold a 7-bit micro-PC (uPC) and a 128-word ROM; each word = 21-bit control, 2-bit seq, 3-bit cond, 7-bit target.
REQ-009 uinstruction SHALL equal the control field of ROM[uPC], combinationally.
REQ-010 seq 00 SHALL give next uPC = uPC+1, wrapping 127 to 0.
REQ-011 seq 01 SHALL give next uPC = target if cond is true, else uPC+1.
REQ-012 cond encoding SHALL be: 000 always, 001 Z, 010 N, 011 C, 100 P, 101 !Z, 110 int, 111 never.
REQ-013 seq 10 (dispatch) SHALL give next uPC = 8 + 2*opcode (range 8..70).
REQ-014 seq 11 (end of instruction) SHALL give next uPC = 4 if int=1, else 0.
REQ-015 Flags, int and opcode SHALL be sampled only in the cycle whose microword uses them; no other internal latching.
REQ-016 ROM[0] SHALL be control 21'h000001, seq 00 (fetch 1); ROM[1] SHALL be control 21'h000002, seq 10 (decode/dispatch).
REQ-017 ROM[4] SHALL be control 21'h040000, seq 00; ROM[5] SHALL be control 21'h020000, seq 11 (interrupt entry).
REQ-018 For opcode k, ROM[8+2k] SHALL be control 21'h100000|k with seq 00; ROM[9+2k] SHALL be control 21'h080000|k with seq 11.
REQ-019 For k = 16, 17, 18, 19, ROM[8+2k] SHALL instead use seq 01, cond Z, N, C, P respectively, target 0, so a true flag skips the second word.
REQ-020 All unused ROM words SHALL be control 0, seq 11.
REQ-021 If int is asserted during the seq-11 cycle, it SHALL take priority over the return to 0; int asserted at any other time SHALL be ignored unless a cond 110 branch is executing.

Reset
REQ-022 rst=1 at a rising edge SHALL set uPC=0, overriding any sequencing; uinstruction then reads 21'h000001.
REQ-023 uPC SHALL also power up to 0 (register initial value), so the output is defined before the first reset edge.
REQ-024 Reset asserted mid-instruction SHALL abandon the routine with no other side effect.

Structure
REQ-025 Seq codes, cond codes, the fetch (0), interrupt (4) and dispatch base (8) addresses, and the word-field widths SHALL live in a shared package, control_unit_pkg.
REQ-026 The ROM SHALL be a sub-module, control_rom (7-bit address in, 33-bit word out), built from a constant function or case table; sequencing logic SHALL stay in control_unit.

Verification
REQ-027 Power-up, rst pulse, int=0, flags=0, opcode=5'b00010, 20 ns clock -> uinstruction sequence 000001, 000002, 100002, 080002, 000001, repeating every 4 cycles.
REQ-028 opcode=5'b10000, Z=1 -> 000001, 000002, 100010, 000001; with Z=0 -> 080010 appears before 000001.
REQ-029 opcode=5'b00010, int=1 held -> after 080002 the next words are 040000, 020000, then 040000 again while int stays 1; int dropped -> 000001.
REQ-030 int pulsed only during the 000002 cycle -> ignored; the normal sequence continues.
REQ-031 rst asserted during word 100002 -> next cycle outputs 000001.
REQ-032 opcode=5'b11111 -> dispatch to uPC 70, outputs 10001F then 08001F.
